// File: rtl/round_sat_pipe.sv
// Two-stage, multi-lane rounding/saturation unit with a valid/ready handshake
// and a clamped counter of saturated-lane events.
module round_sat_pipe #(
    parameter int IL = 10,
    parameter int OL = 7,
    parameter int CH = 2,
    parameter int CW = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iVALID,
    output logic               oREADY,
    input  logic [1:0]         iMODE,
    input  logic [CH*IL-1:0]   iDATA,
    output logic               oVALID,
    input  logic               iREADY,
    output logic [CH*OL-1:0]   oDATA,
    output logic [CH-1:0]      oSAT,
    input  logic               iCLR,
    output logic [CW-1:0]      oSAT_CNT
);

    localparam int RL = IL - OL;
    localparam int PW = $clog2(CH + 1);

    typedef enum logic [1:0] {
        MODE_TRUNC      = 2'd0,
        MODE_HALF_AWAY  = 2'd1,
        MODE_CONVERGENT = 2'd2,
        MODE_HALF_UP    = 2'd3
    } roundMode_t;

    logic [CH-1:0][OL-1:0] w_trunc;
    logic [CH-1:0]         w_half;
    logic [CH-1:0]         w_rest;
    logic [CH-1:0]         w_sign;
    logic [CH-1:0]         w_inc;
    logic [CH-1:0]         w_isMax;

    logic                  r_s1Valid;
    logic [CH-1:0][OL-1:0] r_s1Trunc;
    logic [CH-1:0]         r_s1Inc;
    logic [CH-1:0]         r_s1IsMax;

    logic                  r_oValid;
    logic [CH-1:0][OL-1:0] r_oData;
    logic [CH-1:0]         r_oSat;
    logic [CW-1:0]         r_satCnt;

    logic [CH-1:0][OL-1:0] w_s2Data;
    logic [CH-1:0]         w_s2Sat;
    logic                  w_s2Adv;
    logic                  w_s1Adv;
    logic [PW-1:0]         w_satPop;
    logic [CW:0]           w_cntSum;

    assign w_s2Adv = ~r_oValid | iREADY;
    assign w_s1Adv = ~r_s1Valid | w_s2Adv;

    assign oREADY   = w_s1Adv;
    assign oVALID   = r_oValid;
    assign oDATA    = r_oData;
    assign oSAT     = r_oSat;
    assign oSAT_CNT = r_satCnt;

    // Per-lane split into floor part, half bit, sticky rest and sign; the
    // increment decision is made here so stage 2 only needs an adder.
    always_comb begin
        w_trunc = '0;
        w_half  = '0;
        w_rest  = '0;
        w_sign  = '0;
        w_inc   = '0;
        w_isMax = '0;
        for (int k = 0; k < CH; k++) begin
            w_trunc[k] = iDATA[k*IL+RL +: OL];
            w_half[k]  = iDATA[k*IL+RL-1];
            w_rest[k]  = |iDATA[k*IL +: RL-1];
            w_sign[k]  = iDATA[k*IL+IL-1];
            w_isMax[k] = (w_trunc[k] == {1'b0, {(OL-1){1'b1}}});
            unique case (roundMode_t'(iMODE))
                MODE_TRUNC:      w_inc[k] = 1'b0;
                MODE_HALF_AWAY:  w_inc[k] = w_sign[k] ? (w_half[k] & w_rest[k]) : w_half[k];
                MODE_CONVERGENT: w_inc[k] = w_half[k] & (w_rest[k] | w_trunc[k][0]);
                MODE_HALF_UP:    w_inc[k] = w_half[k];
                default:         w_inc[k] = 1'b0;
            endcase
        end
    end

    // Stage 1 loads only on an accepted beat and holds while stage 2 is stalled.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_s1Valid <= 1'b0;
            r_s1Trunc <= '0;
            r_s1Inc   <= '0;
            r_s1IsMax <= '0;
        end else if (w_s1Adv) begin
            r_s1Valid <= iVALID;
            if (iVALID) begin
                r_s1Trunc <= w_trunc;
                r_s1Inc   <= w_inc;
                r_s1IsMax <= w_isMax;
            end
        end
    end

    // Rounding up from the largest positive code would wrap, so it saturates instead.
    always_comb begin
        w_s2Data = '0;
        w_s2Sat  = '0;
        for (int k = 0; k < CH; k++) begin
            w_s2Sat[k]  = r_s1IsMax[k] & r_s1Inc[k];
            w_s2Data[k] = w_s2Sat[k] ? r_s1Trunc[k] : (r_s1Trunc[k] + OL'(r_s1Inc[k]));
        end
    end

    // Output stage holds its beat stable until downstream takes it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_oValid <= 1'b0;
            r_oData  <= '0;
            r_oSat   <= '0;
        end else if (w_s2Adv) begin
            r_oValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_oData <= w_s2Data;
                r_oSat  <= w_s2Sat;
            end
        end
    end

    always_comb begin
        w_satPop = '0;
        for (int k = 0; k < CH; k++) begin
            w_satPop = w_satPop + PW'(r_oSat[k]);
        end
        w_cntSum = {1'b0, r_satCnt} + (CW+1)'(w_satPop);
    end

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            r_satCnt <= '0;
        end else if (r_oValid && iREADY) begin
            r_satCnt <= w_cntSum[CW] ? {CW{1'b1}} : w_cntSum[CW-1:0];
        end
    end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: a driver pushes arithmetic-model results
// on every accepted beat and a monitor pops and compares on every output transfer.
module tb_round_sat_pipe;

    localparam int IL     = 10;
    localparam int OL     = 7;
    localparam int CH     = 2;
    localparam int CW     = 3;
    localparam int CNTMAX = (1 << CW) - 1;
    localparam int POSMAX = (1 << (OL - 1)) - 1;

    typedef struct {
        logic [CH*OL-1:0] data;
        logic [CH-1:0]    sat;
    } beat_t;

    logic               clock;
    logic               iRST;
    logic               iVALID;
    logic               oREADY;
    logic [1:0]         iMODE;
    logic [CH*IL-1:0]   iDATA;
    logic               oVALID;
    logic               iREADY;
    logic [CH*OL-1:0]   oDATA;
    logic [CH-1:0]      oSAT;
    logic               iCLR;
    logic [CW-1:0]      oSAT_CNT;

    beat_t expQ[$];
    int    checkCount = 0;
    int    passCount  = 0;
    int    inFlight   = 0;
    int    cntModel   = 0;
    bit    started    = 0;

    round_sat_pipe #(.IL(IL), .OL(OL), .CH(CH), .CW(CW)) dut (
        .iCLK     (clock),
        .iRST     (iRST),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .iMODE    (iMODE),
        .iDATA    (iDATA),
        .oVALID   (oVALID),
        .iREADY   (iREADY),
        .oDATA    (oDATA),
        .oSAT     (oSAT),
        .iCLR     (iCLR),
        .oSAT_CNT (oSAT_CNT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Divide by 2^(IL-OL) with the selected rounding rule; returns {sat, value}.
    function automatic logic [OL:0] refLane(input int x, input int mode);
        int  scale;
        int  t;
        int  frac;
        int  res;
        bit  sat;
        scale = 1 << (IL - OL);
        t     = (x >= 0) ? (x / scale) : -((-x + scale - 1) / scale);
        frac  = x - t * scale;
        case (mode)
            0:       res = t;
            1:       res = (x >= 0) ? t + ((frac >= scale / 2) ? 1 : 0) : t + ((frac > scale / 2) ? 1 : 0);
            2:       res = (frac > scale / 2) ? t + 1 : ((frac == scale / 2) ? t + (t & 1) : t);
            default: res = t + ((frac >= scale / 2) ? 1 : 0);
        endcase
        sat = 0;
        if (res > POSMAX) begin
            res = POSMAX;
            sat = 1;
        end
        return {sat, res[OL-1:0]};
    endfunction

    task automatic applyStimulus(input bit valid, input int mode, input int l0, input int l1,
                                 input bit ready, input bit clr, output bit accepted);
        logic [OL:0] e0;
        logic [OL:0] e1;
        beat_t       b;
        @(posedge clock);
        #1;
        iVALID = valid;
        iMODE  = mode[1:0];
        iDATA  = {l1[IL-1:0], l0[IL-1:0]};
        iREADY = ready;
        iCLR   = clr;
        @(negedge clock);
        checkOutput("oREADY", {31'd0, oREADY}, {31'd0, (inFlight < 2) || ready});
        accepted = valid && oREADY;
        if (accepted) begin
            e0     = refLane(l0, mode);
            e1     = refLane(l1, mode);
            b.data = {e1[OL-1:0], e0[OL-1:0]};
            b.sat  = {e1[OL], e0[OL]};
            expQ.push_back(b);
            inFlight++;
        end
        if (oVALID && ready) inFlight--;
    endtask

    task automatic checkResetState();
        @(negedge clock);
        checkOutput("rstOVALID", {31'd0, oVALID}, 32'd0);
        checkOutput("rstODATA", {18'd0, oDATA}, 32'd0);
        checkOutput("rstOSAT", {30'd0, oSAT}, 32'd0);
        checkOutput("rstCNT", {29'd0, oSAT_CNT}, 32'd0);
        checkOutput("rstOREADY", {31'd0, oREADY}, 32'd1);
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        iRST   = 1'b1;
        iVALID = 1'b0;
        iREADY = 1'b0;
        iCLR   = 1'b0;
        @(posedge clock);
        #1;
        expQ.delete();
        inFlight = 0;
        iRST     = 1'b0;
    endtask

    // Monitor: counter model, stall stability and in-order scoreboard compare.
    initial begin
        beat_t exp;
        bit    prevStall;
        logic [CH*OL-1:0] prevData;
        logic [CH-1:0]    prevSat;
        int    pop;
        prevStall = 0;
        prevData  = '0;
        prevSat   = '0;
        forever begin
            @(negedge clock);
            if (started) begin
                checkOutput("satCnt", {29'd0, oSAT_CNT}, cntModel);
                if (iRST) begin
                    prevStall = 0;
                    cntModel  = 0;
                end else begin
                    if (prevStall) begin
                        checkOutput("holdValid", {31'd0, oVALID}, 32'd1);
                        checkOutput("holdData", {18'd0, oDATA}, {18'd0, prevData});
                        checkOutput("holdSat", {30'd0, oSAT}, {30'd0, prevSat});
                    end
                    pop = 0;
                    if (oVALID && iREADY) begin
                        checkOutput("beatExpected", expQ.size() > 0, 32'd1);
                        if (expQ.size() > 0) begin
                            exp = expQ.pop_front();
                            checkOutput("oDATA", {18'd0, oDATA}, {18'd0, exp.data});
                            checkOutput("oSAT", {30'd0, oSAT}, {30'd0, exp.sat});
                            pop = $countones(exp.sat);
                        end
                    end
                    if (iCLR) cntModel = 0;
                    else if (oVALID && iREADY) cntModel = (cntModel + pop > CNTMAX) ? CNTMAX : cntModel + pop;
                    prevStall = oVALID && !iREADY;
                    prevData  = oDATA;
                    prevSat   = oSAT;
                end
            end
        end
    end

    function automatic int randLane();
        if ($urandom_range(3) == 0) return $urandom_range(511, 500);
        return int'($urandom_range(1023)) - 512;
    endfunction

    initial begin
        bit acc;
        int sent;
        iRST   = 1'b1;
        iVALID = 1'b0;
        iMODE  = 2'd0;
        iDATA  = '0;
        iREADY = 1'b0;
        iCLR   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        iRST = 1'b0;
        checkResetState();
        started = 1;

        applyStimulus(1, 1, 13, -12, 1, 0, acc);
        applyStimulus(1, 2, 12, 20, 1, 0, acc);
        applyStimulus(1, 3, -12, 0, 1, 0, acc);
        applyStimulus(1, 0, 13, -12, 1, 0, acc);
        applyStimulus(1, 1, 511, -512, 1, 0, acc);
        applyStimulus(1, 0, 511, 0, 1, 0, acc);
        applyStimulus(1, 2, 508, -4, 1, 0, acc);
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 0, acc);

        sent = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(sent < 5, 3, 100 + 8 * sent + 4, -(20 + sent), !(c >= 2 && c <= 6), 0, acc);
            if (acc) sent++;
        end
        checkOutput("streamSent", sent, 32'd5);

        for (int n = 0; n < 6; n++) applyStimulus(1, 1, 511, 510, 1, 0, acc);
        applyStimulus(0, 0, 0, 0, 1, 0, acc);
        applyStimulus(0, 0, 0, 0, 1, 1, acc);
        applyStimulus(1, 1, 511, 0, 1, 0, acc);
        applyStimulus(0, 0, 0, 0, 1, 1, acc);
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, acc);

        applyStimulus(1, 1, 40, 41, 0, 0, acc);
        applyStimulus(1, 2, 42, 43, 0, 0, acc);
        doReset();
        checkResetState();

        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                doReset();
                checkResetState();
            end
            applyStimulus($urandom_range(3) != 0, $urandom_range(3), randLane(), randLane(),
                          $urandom_range(3) != 0, $urandom_range(39) == 0, acc);
        end

        for (int c = 0; c < 20 && expQ.size() > 0; c++) applyStimulus(0, 0, 0, 0, 1, 0, acc);
        checkOutput("drained", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
